// File: rtl/hsv_pkg.sv
// Shared constants for the HSV-to-RGB converter: hue sector codes and pipeline sizing.
package hsv_pkg;

    localparam int COLOR_W  = 8;
    localparam int PIPE_LAT = 4;

    typedef enum logic [2:0] {
        SEC_RY = 3'd0,
        SEC_YG = 3'd1,
        SEC_GC = 3'd2,
        SEC_CB = 3'd3,
        SEC_BM = 3'd4,
        SEC_MR = 3'd5
    } sector_t;

endpackage

// File: rtl/hsv2rgb_mul.sv
// Registered unsigned 8x9 multiply keeping bits [15:8] of the product, gated by ce.
module hsv2rgb_mul
    import hsv_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic [COLOR_W-1:0] i_a,
    input  logic [COLOR_W:0]   i_b,
    output logic [COLOR_W-1:0] o_p
);

    logic [2*COLOR_W:0] w_prod;
    logic [COLOR_W-1:0] r_p;

    // i_a <= 255 and i_b <= 256, so the shifted product always fits in COLOR_W bits.
    assign w_prod = {{(COLOR_W+1){1'b0}}, i_a} * {{COLOR_W{1'b0}}, i_b};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_p <= '0;
        end else if (ce) begin
            r_p <= COLOR_W'(w_prod >> COLOR_W);
        end
    end

    assign o_p = r_p;

endmodule

// File: rtl/hsv2rgb.sv
// Four-stage HSV to RGB pixel pipeline; syncs and de are delayed to match the data.
module hsv2rgb
    import hsv_pkg::*;
#(
    parameter bit BLANK_ZERO = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic [COLOR_W-1:0] H,
    input  logic [COLOR_W-1:0] S,
    input  logic [COLOR_W-1:0] V,
    input  logic               in_hsync,
    input  logic               in_vsync,
    input  logic               in_de,
    output logic [COLOR_W-1:0] R,
    output logic [COLOR_W-1:0] G,
    output logic [COLOR_W-1:0] B,
    output logic               out_hsync,
    output logic               out_vsync,
    output logic               out_de
);

    logic [COLOR_W+2:0] w_hx;
    logic [COLOR_W:0]   w_ns;
    logic [COLOR_W:0]   w_nf;

    sector_t            r1_sec, r2_sec, r3_sec;
    logic [COLOR_W-1:0] r1_f, r1_s, r1_v;
    logic [COLOR_W:0]   r1_ns, r1_nf;
    logic [COLOR_W-1:0] r2_v, r3_v, r3_p;

    logic [COLOR_W-1:0] w_sf, w_snf, w_p, w_q, w_t;
    logic [COLOR_W:0]   w_b_q, w_b_t;
    logic [COLOR_W-1:0] w_r, w_g, w_b;

    logic [COLOR_W-1:0] r_r, r_g, r_b;
    logic [PIPE_LAT-1:0] r_hs, r_vs, r_de;

    assign w_hx = {3'b000, H} * (COLOR_W+3)'(6);
    assign w_ns = (COLOR_W+1)'(256) - {1'b0, S};
    assign w_nf = (COLOR_W+1)'(256) - {1'b0, w_hx[COLOR_W-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_sec <= SEC_RY;
            r1_f   <= '0;
            r1_s   <= '0;
            r1_v   <= '0;
            r1_ns  <= '0;
            r1_nf  <= '0;
            r2_sec <= SEC_RY;
            r2_v   <= '0;
            r3_sec <= SEC_RY;
            r3_v   <= '0;
            r3_p   <= '0;
        end else if (ce) begin
            r1_sec <= sector_t'(w_hx[COLOR_W+2:COLOR_W]);
            r1_f   <= w_hx[COLOR_W-1:0];
            r1_s   <= S;
            r1_v   <= V;
            r1_ns  <= w_ns;
            r1_nf  <= w_nf;
            r2_sec <= r1_sec;
            r2_v   <= r1_v;
            r3_sec <= r2_sec;
            r3_v   <= r2_v;
            r3_p   <= w_p;
        end
    end

    hsv2rgb_mul u_mul_sf  (.clk(clk), .rst(rst), .ce(ce), .i_a(r1_s), .i_b({1'b0, r1_f}), .o_p(w_sf));
    hsv2rgb_mul u_mul_snf (.clk(clk), .rst(rst), .ce(ce), .i_a(r1_s), .i_b(r1_nf),        .o_p(w_snf));
    hsv2rgb_mul u_mul_p   (.clk(clk), .rst(rst), .ce(ce), .i_a(r1_v), .i_b(r1_ns),        .o_p(w_p));

    assign w_b_q = (COLOR_W+1)'(256) - {1'b0, w_sf};
    assign w_b_t = (COLOR_W+1)'(256) - {1'b0, w_snf};

    hsv2rgb_mul u_mul_q   (.clk(clk), .rst(rst), .ce(ce), .i_a(r2_v), .i_b(w_b_q),        .o_p(w_q));
    hsv2rgb_mul u_mul_t   (.clk(clk), .rst(rst), .ce(ce), .i_a(r2_v), .i_b(w_b_t),        .o_p(w_t));

    always_comb begin
        w_r = r3_v;
        w_g = r3_p;
        w_b = w_q;
        case (r3_sec)
            SEC_RY:  begin w_r = r3_v; w_g = w_t;  w_b = r3_p; end
            SEC_YG:  begin w_r = w_q;  w_g = r3_v; w_b = r3_p; end
            SEC_GC:  begin w_r = r3_p; w_g = r3_v; w_b = w_t;  end
            SEC_CB:  begin w_r = r3_p; w_g = w_q;  w_b = r3_v; end
            SEC_BM:  begin w_r = w_t;  w_g = r3_p; w_b = r3_v; end
            default: begin w_r = r3_v; w_g = r3_p; w_b = w_q;  end
        endcase
    end

    // r_de[PIPE_LAT-2] is the de that lands on out_de at the same edge as this RGB.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_r  <= '0;
            r_g  <= '0;
            r_b  <= '0;
            r_hs <= '0;
            r_vs <= '0;
            r_de <= '0;
        end else if (ce) begin
            if (BLANK_ZERO && !r_de[PIPE_LAT-2]) begin
                r_r <= '0;
                r_g <= '0;
                r_b <= '0;
            end else begin
                r_r <= w_r;
                r_g <= w_g;
                r_b <= w_b;
            end
            r_hs <= {r_hs[PIPE_LAT-2:0], in_hsync};
            r_vs <= {r_vs[PIPE_LAT-2:0], in_vsync};
            r_de <= {r_de[PIPE_LAT-2:0], in_de};
        end
    end

    assign R         = r_r;
    assign G         = r_g;
    assign B         = r_b;
    assign out_hsync = r_hs[PIPE_LAT-1];
    assign out_vsync = r_vs[PIPE_LAT-1];
    assign out_de    = r_de[PIPE_LAT-1];

endmodule

// File: tb/tb_hsv2rgb.sv
// Bench for hsv2rgb: two instances (blanking on/off) checked against an arithmetic HSV model.
module tb_hsv2rgb;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce  = 1'b1;
    logic [7:0] H = 8'd0, S = 8'd0, V = 8'd0;
    logic       hs = 1'b0, vs = 1'b0, de = 1'b0;

    logic [7:0] bz_r, bz_g, bz_b, nb_r, nb_g, nb_b;
    logic       bz_hs, bz_vs, bz_de, nb_hs, nb_vs, nb_de;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hsv2rgb #(.BLANK_ZERO(1'b1)) dut_bz (
        .clk(clk), .rst(rst), .ce(ce), .H(H), .S(S), .V(V),
        .in_hsync(hs), .in_vsync(vs), .in_de(de),
        .R(bz_r), .G(bz_g), .B(bz_b),
        .out_hsync(bz_hs), .out_vsync(bz_vs), .out_de(bz_de)
    );

    hsv2rgb #(.BLANK_ZERO(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .ce(ce), .H(H), .S(S), .V(V),
        .in_hsync(hs), .in_vsync(vs), .in_de(de),
        .R(nb_r), .G(nb_g), .B(nb_b),
        .out_hsync(nb_hs), .out_vsync(nb_vs), .out_de(nb_de)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Plain integer rendering of the hexcone formulas with truncating divides.
    function automatic logic [23:0] rgb_of(input int h, input int s, input int v);
        int hx, sec, f, p, q, t, r, g, b;
        hx  = h * 6;
        sec = hx / 256;
        f   = hx % 256;
        p   = (v * (256 - s)) / 256;
        q   = (v * (256 - (s * f) / 256)) / 256;
        t   = (v * (256 - (s * (256 - f)) / 256)) / 256;
        case (sec)
            0:       begin r = v; g = t; b = p; end
            1:       begin r = q; g = v; b = p; end
            2:       begin r = p; g = v; b = t; end
            3:       begin r = p; g = q; b = v; end
            4:       begin r = t; g = p; b = v; end
            default: begin r = v; g = p; b = q; end
        endcase
        return {r[7:0], g[7:0], b[7:0]};
    endfunction

    typedef struct {
        logic [7:0] h, s, v;
        logic       hs, vs, de;
    } pix_t;

    pix_t hist[4];
    int   fill = 0;

    // Model: remember the last four enabled input samples; output reflects the oldest.
    always @(posedge clk) begin
        logic [23:0] e_rgb;
        logic [2:0]  e_sync;
        if (rst) begin
            fill = 0;
        end else if (ce) begin
            for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = '{H, S, V, hs, vs, de};
            if (fill < 4) fill++;
        end
        #1;
        if (fill == 4) begin
            e_rgb  = rgb_of(int'(hist[3].h), int'(hist[3].s), int'(hist[3].v));
            e_sync = {hist[3].hs, hist[3].vs, hist[3].de};
        end else begin
            e_rgb  = 24'd0;
            e_sync = 3'd0;
        end
        check("nb_rgb",  {8'd0, nb_r, nb_g, nb_b}, {8'd0, e_rgb});
        check("bz_rgb",  {8'd0, bz_r, bz_g, bz_b}, {8'd0, (e_sync[0] ? e_rgb : 24'd0)});
        check("nb_sync", {29'd0, nb_hs, nb_vs, nb_de}, {29'd0, e_sync});
        check("bz_sync", {29'd0, bz_hs, bz_vs, bz_de}, {29'd0, e_sync});
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            H = 8'd0; S = 8'd0; V = 8'd0; hs = 1'b0; vs = 1'b0; de = 1'b0;
        end
    endtask

    // One de=1 pixel, then read the output after the fourth edge.
    task automatic lit(input string nm, input logic [7:0] h, input logic [7:0] s,
                       input logic [7:0] v, input logic [23:0] exp);
        @(negedge clk);
        H = h; S = s; V = v; de = 1'b1;
        @(negedge clk);
        H = 8'd0; S = 8'd0; V = 8'd0; de = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check(nm, {8'd0, nb_r, nb_g, nb_b}, {8'd0, exp});
        check({nm, "_de"}, {31'd0, nb_de}, 32'd1);
    endtask

    logic [23:0] got_q[$];
    logic [23:0] exp_q[$];

    initial begin
        // Model pinning against hand arithmetic.
        check("model_h43", {8'd0, rgb_of(43, 255, 255)}, 32'h00FEFF00);
        check("model_h85", {8'd0, rgb_of(85, 255, 255)}, 32'h0002FF00);
        check("model_grey", {8'd0, rgb_of(100, 0, 200)}, 32'h00C8C8C8);

        repeat (3) @(posedge clk);
        #2;
        check("reset_bz", {20'd0, bz_r, bz_hs, bz_vs, bz_de, bz_g[0]}, 32'd0);
        check("reset_nb", {8'd0, nb_r, nb_g, nb_b}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(5);

        lit("red",     8'd0,   8'd255, 8'd255, 24'hFF0000);
        lit("h85",     8'd85,  8'd255, 8'd255, 24'h02FF00);
        lit("h171",    8'd171, 8'd255, 8'd255, 24'h0200FF);
        lit("h43",     8'd43,  8'd255, 8'd255, 24'hFEFF00);
        lit("grey0",   8'd0,   8'd0,   8'd200, 24'hC8C8C8);
        lit("grey100", 8'd100, 8'd0,   8'd200, 24'hC8C8C8);
        lit("grey255", 8'd255, 8'd0,   8'd200, 24'hC8C8C8);
        lit("black",   8'd77,  8'd190, 8'd0,   24'h000000);
        idle(6);

        // 16-pixel line: de on cycles 3..12, hsync on 14.
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("line_de", {31'd0, bz_de}, {31'd0, (k >= 7 && k <= 16)});
            check("line_hs", {31'd0, bz_hs}, {31'd0, (k == 18)});
            check("line_bz_r", {24'd0, bz_r}, (k >= 7 && k <= 16) ? 32'd200 : 32'd0);
            check("line_nb_r", {24'd0, nb_r}, (k >= 4) ? 32'd200 : 32'd0);
            H  = (k < 16) ? 8'(k * 16) : 8'd0;
            S  = 8'd0;
            V  = (k < 16) ? 8'd200 : 8'd0;
            de = (k >= 3 && k <= 12);
            hs = (k == 14);
        end
        idle(6);

        // Distinct pixels with ce low for three cycles mid-stream.
        for (int j = 0; j < 12; j++)
            exp_q.push_back(rgb_of(j * 21, 255 - j * 9, 90 + j * 13));
        begin
            int idx = 0;
            for (int c = 0; c < 30; c++) begin
                logic ce_now;
                @(negedge clk);
                ce = !(c >= 5 && c <= 7);
                if (idx < 12) begin
                    H = 8'(idx * 21); S = 8'(255 - idx * 9); V = 8'(90 + idx * 13);
                    de = 1'b1; vs = idx[0];
                end else begin
                    H = 8'd0; S = 8'd0; V = 8'd0; de = 1'b0; vs = 1'b0;
                end
                ce_now = ce;
                if (ce) idx++;
                @(posedge clk);
                #2;
                if (ce_now && nb_de) got_q.push_back({nb_r, nb_g, nb_b});
            end
        end
        check("ce_count", got_q.size(), 32'd12);
        for (int j = 0; j < 12; j++)
            check("ce_seq", {8'd0, (j < got_q.size()) ? got_q[j] : 24'hxxxxxx}, {8'd0, exp_q[j]});
        @(negedge clk);
        ce = 1'b1;
        idle(4);

        // Reset mid-stream.
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            H = 8'(j * 40); S = 8'd200; V = 8'd250; de = 1'b1;
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
        check("rst_flush_nb", {5'd0, nb_r, nb_g, nb_b, nb_hs, nb_vs, nb_de}, 32'd0);
        check("rst_flush_bz", {5'd0, bz_r, bz_g, bz_b, bz_hs, bz_vs, bz_de}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        H = 8'd10; S = 8'd255; V = 8'd255; de = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #2;
            check("rst_first_de", {31'd0, nb_de}, {31'd0, (k >= 4)});
            @(negedge clk);
            H = 8'(10 + k * 30);
        end
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
